// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared state encoding, sizes and index helpers for the select sequencer
package mux_seq_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int NUM_IN = 8;
    localparam int SEL_W  = 3;
    function automatic logic [SEL_W-1:0] start_idx(input bit msb_first);
        return msb_first ? 3'd7 : 3'd0;
    endfunction
    function automatic logic [SEL_W-1:0] end_idx(input bit msb_first);
        return msb_first ? 3'd0 : 3'd7;
    endfunction
endpackage

// File: rtl/bit_hold_counter_v.sv
// bit_hold_counter_v: counts clocks per select index and ticks on the last one
module bit_hold_counter_v #(
    parameter int BIT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);
    logic [7:0] r_cnt;
    assign o_tick = i_en && (r_cnt == LAST);
    // hold counter: clear on request, wrap to zero on the tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= 8'd0;
        else if (i_clr || o_tick)
            r_cnt <= 8'd0;
        else if (i_en)
            r_cnt <= r_cnt + 8'd1;
    end
endmodule

// File: rtl/mux_sel_sequencer_v.sv
// mux_sel_sequencer_v: captures a word and walks the 8:1 mux select across it
module mux_sel_sequencer_v
    import mux_seq_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start_valid,
    output logic              o_start_ready,
    input  logic [NUM_IN-1:0] i_word,
    input  logic              i_abort,
    output logic [NUM_IN-1:0] o_code,
    output logic [SEL_W-1:0]  o_sel_code,
    output logic              o_en,
    output logic              o_first,
    output logic              o_last,
    output logic              o_done,
    output logic              o_busy
);
    localparam logic [SEL_W-1:0] SEL_START = start_idx(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_END   = end_idx(MSB_FIRST);
    state_t              r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt;
    logic [NUM_IN-1:0]   r_code, w_code_nxt;
    logic                w_run, w_tick, w_done, w_hs;
    assign w_run  = (r_state == RUN);
    assign w_done = w_run && (r_sel == SEL_END) && w_tick;
    // ready in idle or on the final beat so frames can abut; abort and reset veto it
    assign o_start_ready = i_rst_n && !i_abort && (!w_run || w_done);
    assign w_hs          = i_start_valid && o_start_ready;
    bit_hold_counter_v #(.BIT_CYCLES(BIT_CYCLES)) u_hold (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_hs || i_abort),
        .i_en    (w_run),
        .o_tick  (w_tick)
    );
    // state, index and captured word registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_sel   <= SEL_START;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_code  <= w_code_nxt;
        end
    end
    // next state: handshake starts a frame, abort or final beat returns to idle
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_code_nxt  = r_code;
        if (w_hs) begin
            w_state_nxt = RUN;
            w_sel_nxt   = SEL_START;
            w_code_nxt  = i_word;
        end else if (w_run && (i_abort || w_done)) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = SEL_START;
        end else if (w_run && w_tick) begin
            w_sel_nxt   = MSB_FIRST ? r_sel - 3'd1 : r_sel + 3'd1;
        end
    end
    assign o_code     = r_code;
    assign o_sel_code = r_sel;
    assign o_en       = w_run;
    assign o_busy     = w_run;
    assign o_first    = w_run && (r_sel == SEL_START);
    assign o_last     = w_run && (r_sel == SEL_END);
    assign o_done     = w_done;
endmodule

// File: doc/mux_sel_sequencer_v.md
Name: mux_sel_sequencer_v

Overview:
- Upstream control stage for the 8:1 select mux (MUX_8_1 family).
- Accepts an 8-bit word via a valid/ready handshake and holds it on o_code.
- Steps o_sel_code through all 8 indices, holding each index for BIT_CYCLES clocks, with o_en high while a frame is active.
- Mux output therefore serialises the word one bit per index; o_first, o_last and o_done frame the stream for the downstream consumer.

Parameters:
- BIT_CYCLES, 1, clocks each select index is held; legal range 1..255.
- MSB_FIRST, 0: 0 steps sel 0→7; 1 steps sel 7→0.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start_valid  input  1  word on i_word is offered.
- o_start_ready  output  1  sequencer accepts the word this cycle.
- i_word  input  8  word to serialise; sampled only on handshake.
- i_abort  input  1  synchronous frame abort.
- o_code  output  8  registered word; drives the mux i_code.
- o_sel_code  output  3  current index; drives the mux i_sel_code.
- o_en  output  1  drives the mux i_en; high only during a frame.
- o_first  output  1  high while the first index of the frame is presented.
- o_last  output  1  high while the last index of the frame is presented.
- o_done  output  1  high for exactly the final cycle of a completed frame.
- o_busy  output  1  frame in progress.

Behaviour:
- Reset (asynchronous, i_rst_n=0): all outputs are forced immediately.
  - State=IDLE.
  - o_code=0, o_en=0, o_first=0, o_last=0, o_done=0, o_busy=0.
  - o_sel_code=START (0 if MSB_FIRST=0, else 7).
  - Hold counter=0, o_start_ready=0 while reset is asserted.
  - Reset during a frame discards the frame; no o_done.
- States: IDLE, RUN.
- IDLE:
  - o_start_ready=1, o_en=0, o_sel_code=START.
  - A handshake (i_start_valid & o_start_ready) captures o_code<=i_word, sets hold counter=0, and moves to RUN.
  - First RUN cycle is the cycle after the handshake (latency 1).
- RUN:
  - o_en=1, o_busy=1.
  - Hold counter increments each cycle.
  - When the counter reaches BIT_CYCLES-1: counter clears and o_sel_code steps (+1, or -1 if MSB_FIRST).
- Flags:
  - o_first=1 while o_sel_code=START.
  - o_last=1 while o_sel_code=END (7 or 0).
  - o_done=1 only when o_last=1 and the counter is at BIT_CYCLES-1.
- Frame length: exactly 8*BIT_CYCLES cycles with o_en=1.
- Index wrap: the index never wraps inside a frame. After END it returns to START in IDLE or in the next frame.
- Back-to-back frames:
  - o_start_ready is also 1 during the o_done cycle.
  - A handshake in that cycle starts a new frame on the next cycle: o_code updates, o_sel_code=START, o_first=1, and o_en stays 1 with no gap.
  - With no handshake, the block returns to IDLE with o_en=0.
- Abort:
  - i_abort=1 in RUN → IDLE next cycle, o_en=0, no o_done, o_code retained.
  - i_abort has priority over a same-cycle handshake; that handshake is refused because o_start_ready is forced to 0 when i_abort=1.
  - i_abort in IDLE has no effect other than blocking the handshake.
- i_word is ignored outside the handshake cycle; o_code is stable for the whole frame.
- All outputs are registered except o_start_ready, which is combinational from state, o_done and i_abort.

Decomposition:
- Shared package/include mux_seq_pkg holds:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - NUM_IN=8, SEL_W=3.
  - START/END index functions of MSB_FIRST.
- One natural sub-module: bit_hold_counter_v.
  - Parameterised on BIT_CYCLES.
  - Clear and enable inputs; emits a one-cycle o_tick at count BIT_CYCLES-1.
  - The FSM uses o_tick to step the index.

Test Plan:
- Basic serialisation: BIT_CYCLES=1, MSB_FIRST=0, i_word=8'hA5 handshake at cycle 0.
  - Cycles 1..8: o_sel_code 0..7, o_en=1.
  - Downstream mux o_f = 1,0,1,0,0,1,0,1.
  - o_first at cycle 1; o_last and o_done at cycle 8; o_en=0 at cycle 9.
- Hold and direction: BIT_CYCLES=3, MSB_FIRST=1, i_word=8'h81.
  - Each sel 7..0 is held 3 cycles; o_en is high for 24 cycles.
  - o_f = 1 for cycles 1-3, 0 for cycles 4-21, 1 for cycles 22-24; o_done only at cycle 24.
- Back-to-back frames: 8'hFF then 8'h00 offered continuously with BIT_CYCLES=1.
  - Second handshake occurs at cycle 8 (o_done cycle).
  - Cycle 9: o_sel_code=0, o_code=8'h00, o_first=1; o_en never drops.
  - o_f = eight 1s then eight 0s.
- Abort mid-frame: abort at cycle 4 of an 8'h3C frame, with i_start_valid=1 in the same cycle.
  - Handshake is refused; cycle 5: o_en=0, o_busy=0, o_sel_code=0.
  - o_done never asserts; a new handshake at cycle 5 is accepted.
- Asynchronous reset mid-frame: i_rst_n low between clock edges at cycle 3.
  - o_en, o_busy and o_code drop to 0 before the next edge.
  - After release, the block sits in IDLE with o_start_ready=1 and no o_done.
- No-valid idle: i_start_valid=0 for 20 cycles → o_en=0 and o_sel_code=0 throughout; i_word toggling does not change o_code.
